uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Recovers bytes from the asynchronous RxD line.
- Presents each good byte on RxD_data with a one-cycle RxD_ready strobe.
- Directly feeds the receive control unit, which pairs consecutive bytes (MSB first, then LSB) into one FIR input sample.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), cycles from start-bit edge to start-bit mid-sample.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line; idle high.
- RxD_data  output  8  last correctly received byte.
- RxD_ready  output  1  one-clk pulse: RxD_data has just been updated.
- frame_err  output  1  one-clk pulse: stop bit sampled low, byte discarded.
- rx_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous, active-high.
- Reset values:
  - RxD_data=8'h00, RxD_ready=0, frame_err=0, rx_busy=0.
  - State=IDLE; bit counter=0; cycle counter=0.
  - Both synchronizer flops=1.
- Input sync: 2-flop synchronizer on RxD; rxs is the 2nd flop output. All decisions use rxs. Synchronizer latency is 2 clks.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, cycle counter cleared. Otherwise stay.
  - START: count cycles. At count==HALF_BIT-1, sample rxs:
    - rxs==0 -> DATA, counter cleared, bit index=0.
    - rxs==1 -> IDLE (glitch rejected; no outputs).
  - DATA: count to CLKS_PER_BIT-1, then sample rxs into shift register position [bit index] (LSB first) and clear counter.
    - After bit index 7 is sampled -> STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rxs:
    - rxs==1: load RxD_data from shift register; RxD_ready=1 on the next clk only -> IDLE.
    - rxs==0: RxD_data unchanged; frame_err=1 on the next clk only -> BREAK.
  - BREAK: wait for rxs==1 -> IDLE. A held-low line never starts a false frame.
- Outputs:
  - rx_busy = (state != IDLE).
  - RxD_ready and frame_err are never high together; each is high at most 1 clk per frame.
  - RxD_data holds its value between frames.
- Timing:
  - Bit k (k=0..7) is sampled HALF_BIT + (k+1)*CLKS_PER_BIT - 1 cycles after START is entered.
  - The stop bit is sampled CLKS_PER_BIT cycles after bit 7.
  - RxD_ready rises 1 clk after the stop sample.
- Back-to-back frames:
  - The stop sample lands mid stop bit and IDLE is re-entered immediately.
  - The next start edge is therefore caught with at most 1-clk added detection skew.
  - No minimum idle gap is required.
- Reset mid-frame: at any state, rst forces all reset values on the next edge. The partial byte is discarded; no RxD_ready or frame_err is issued.
- No internal buffering: a consumer that misses the RxD_ready pulse loses the strobe. The downstream control unit samples it every clk.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8, bit period 16 clks; all expected values are for this setting):
- Single frame: drive 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop) -> exactly one RxD_ready pulse, RxD_data==8'hA5, frame_err never high, rx_busy low after.
- Back-to-back: 0x12 then 0x34 with zero idle between -> two RxD_ready pulses 160 clks apart (±1), RxD_data 8'h12 then 8'h34.
- Start glitch: RxD low for 4 clks, then high for 20 bit-times -> no RxD_ready, no frame_err, rx_busy drops within HALF_BIT+3 clks.
- Framing error: first receive 0x0F, then send 0x55 with stop bit low, line held low 3 bit-times, then high, then 0xC3:
  - 0x55 -> one frame_err pulse, no RxD_ready, RxD_data stays 8'h0F.
  - 0xC3 -> received as 8'hC3.
- Reset mid-frame: assert rst for 1 clk after 4 data bits of 0xFF -> outputs at reset values next clk, no strobe. Then send 0x3C -> RxD_data==8'h3C with one RxD_ready.
- Downstream pairing: send 0xAB then 0xCD -> two RxD_ready pulses; the control unit observes MSB 8'hAB then LSB 8'hCD.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. Recovers bytes from the asynchronous RxD line,
// strobing RxD_ready on good bytes and frame_err on a low stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_ready,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ferr;
    logic            w_rxs;

    assign w_rxs = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // A start bit that is already high again at mid-bit is a glitch.
                        r_state <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        r_idx          <= r_idx + 1'b1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_data  <= r_shift;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Held-low line must return high before a new start can be seen.
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign RxD_data  = r_data;
    assign RxD_ready = r_ready;
    assign frame_err = r_ferr;
    assign rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clks/bit: stimulus pushes expected bytes and
// paired samples; a negedge monitor pops and compares on every RxD_ready.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_ready;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
        .clk       (clk),
        .rst       (rst),
        .RxD       (RxD),
        .RxD_data  (RxD_data),
        .RxD_ready (RxD_ready),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    int n_cmp;
    int n_bad;
    int cyc;
    int ferr_cnt;
    logic [7:0]  exp_q[$];
    logic [15:0] samp_q[$];
    int          ready_times[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard for bytes plus a model of the downstream MSB/LSB pairing unit.
    logic       pair_phase;
    logic [7:0] pair_msb;
    always @(negedge clk) begin
        if (!rst) begin
            if (RxD_ready && frame_err) begin
                check("ready_and_ferr_together", 1, 0);
            end
            if (RxD_ready) begin
                ready_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    check("rx_byte", int'(RxD_data), int'(exp_q.pop_front()));
                end
                if (!pair_phase) begin
                    pair_msb   = RxD_data;
                    pair_phase = 1'b1;
                end else begin
                    pair_phase = 1'b0;
                    if (samp_q.size() == 0) begin
                        check("unexpected_sample", 1, 0);
                    end else begin
                        check("paired_sample", int'({pair_msb, RxD_data}), int'(samp_q.pop_front()));
                    end
                end
            end
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic hold(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int stop_len);
        hold(1'b0, CPB);
        for (int unsigned i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_v, stop_len);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int r0, f0, t_rise, t_fall;
        n_cmp = 0; n_bad = 0; cyc = 0; ferr_cnt = 0;
        pair_phase = 1'b0; pair_msb = '0;
        rst = 1'b1;
        RxD = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_data",  int'(RxD_data),  0);
        check("reset_ready", int'(RxD_ready), 0);
        check("reset_ferr",  int'(frame_err), 0);
        check("reset_busy",  int'(rx_busy),   0);
        hold(1'b1, 2 * CPB);

        // Single frame
        exp_q.push_back(8'hA5);
        samp_q.push_back(16'hA512);
        send_byte(8'hA5, 1'b1, CPB);
        hold(1'b1, 2 * CPB);
        check("busy_after_a5", int'(rx_busy), 0);
        check("ready_count_a5", ready_times.size(), 1);

        // Back-to-back, no idle gap
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        samp_q.push_back(16'h340F);
        send_byte(8'h12, 1'b1, CPB);
        send_byte(8'h34, 1'b1, CPB);
        hold(1'b1, 2 * CPB);
        check("ready_count_b2b", ready_times.size(), 3);
        if (ready_times.size() >= 3) begin
            int d;
            d = ready_times[2] - ready_times[1];
            check("b2b_spacing_in_range", int'(d >= 159 && d <= 161), 1);
        end

        // Start glitch: 4 clks low
        r0 = ready_times.size();
        f0 = ferr_cnt;
        t_rise = -1;
        t_fall = -1;
        RxD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rx_busy && t_rise < 0) t_rise = cyc;
        end
        RxD = 1'b1;
        for (int i = 0; i < 20 && t_fall < 0; i++) begin
            @(negedge clk);
            if (t_rise < 0 && rx_busy) t_rise = cyc;
            if (t_rise >= 0 && !rx_busy) t_fall = cyc;
        end
        check("glitch_busy_rose", int'(t_rise >= 0), 1);
        check("glitch_busy_fell_in_time", int'(t_fall >= 0 && (t_fall - t_rise) <= HALF + 3), 1);
        hold(1'b1, 20 * CPB);
        check("glitch_no_ready", ready_times.size(), r0);
        check("glitch_no_ferr",  ferr_cnt, f0);

        // Framing error: good 0x0F, then 0x55 with low stop held 3 bit-times, then 0xC3
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1, CPB);
        hold(1'b1, CPB);
        r0 = ready_times.size();
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0, 3 * CPB);
        check("ferr_pulse_count", ferr_cnt, f0 + 1);
        check("ferr_no_ready", ready_times.size(), r0);
        check("ferr_data_held", int'(RxD_data), 8'h0F);
        check("ferr_busy_in_break", int'(rx_busy), 1);
        hold(1'b1, 2 * CPB);
        check("ferr_idle_after_break", int'(rx_busy), 0);
        exp_q.push_back(8'hC3);
        samp_q.push_back(16'hC33C);
        send_byte(8'hC3, 1'b1, CPB);
        hold(1'b1, CPB);
        check("after_ferr_data", int'(RxD_data), 8'hC3);

        // Reset mid-frame after 4 data bits of 0xFF
        r0 = ready_times.size();
        f0 = ferr_cnt;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b1, CPB);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_data",  int'(RxD_data),  0);
        check("midrst_ready", int'(RxD_ready), 0);
        check("midrst_ferr",  int'(frame_err), 0);
        check("midrst_busy",  int'(rx_busy),   0);
        rst = 1'b0;
        hold(1'b1, 8 * CPB);
        check("midrst_no_strobe", ready_times.size() + ferr_cnt, r0 + f0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, CPB);
        hold(1'b1, CPB);
        check("after_rst_data", int'(RxD_data), 8'h3C);

        // Downstream pairing
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        samp_q.push_back(16'hABCD);
        send_byte(8'hAB, 1'b1, CPB);
        send_byte(8'hCD, 1'b1, CPB);
        hold(1'b1, 2 * CPB);

        check("total_ready_count", ready_times.size(), 8);
        check("total_ferr_count", ferr_cnt, 1);
        check("byte_queue_drained", exp_q.size(), 0);
        check("sample_queue_drained", samp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
